// File: rtl/mau_pkg.sv
// mau_pkg -- shared definitions for the memory access unit.
//   SIZE_*      : request/bus size encodings (2'b11 is folded onto byte)
//   mau_state_t : FSM state encoding (IDLE, BUS, RESP)
//   STDOUT_ADDR / EXIT_ADDR : well-known store targets; they travel over the
//                             bus like any other address
//   norm_size() : folds the reserved 2'b11 size onto byte
package mau_pkg;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   localparam logic [31:0] STDOUT_ADDR = 32'hf000_0000;
   localparam logic [31:0] EXIT_ADDR   = 32'hff00_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_RESP = 2'b10
   } mau_state_t;

   function automatic logic [1:0] norm_size(input logic [1:0] s);
      return (s == 2'b11) ? SIZE_BYTE : s;
   endfunction

endpackage

// File: rtl/mau_align.sv
// mau_align -- combinational data steering between the pipeline and the bus.
//   size       : normalised transfer size (SIZE_WORD/HALF/BYTE)
//   is_signed  : sign-extend half/byte loads when set
//   load_raw   : data as seen on the bus (DDT_in)
//   store_raw  : right-justified store data from the pipeline
//   load_data  : extended load result (word unchanged)
//   store_data : bus write data, narrow sizes in the low bits, upper bits 0
module mau_align
   import mau_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [31:0] load_raw,
   input  logic [31:0] store_raw,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   always_comb begin
      load_data  = load_raw;
      store_data = store_raw;
      case (size)
         SIZE_WORD: begin
            load_data  = load_raw;
            store_data = store_raw;
         end
         SIZE_HALF: begin
            load_data  = {{16{is_signed & load_raw[15]}}, load_raw[15:0]};
            store_data = {16'h0000, store_raw[15:0]};
         end
         default: begin
            load_data  = {{24{is_signed & load_raw[7]}}, load_raw[7:0]};
            store_data = {24'h000000, store_raw[7:0]};
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit -- bridges a pipeline load/store request onto a simple
// MREQ/ACKD_n memory bus and returns one completion pulse per request.
//   clk, rst            : clock; synchronous active-low reset
//   req_*               : pipeline request (valid/ready handshake)
//   resp_valid/rdata/err: one-cycle completion with extended load data
//   DAD, DDT_*          : bus address, write data/enable, read data
//   MREQ, WRITE, SIZE   : bus request, direction, size
//   ACKD_n              : active-low bus acknowledge (only looked at in BUS)
//   dbg_state           : current FSM state, for observation
// Parameter TIMEOUT (1..255): BUS cycles without ACK before an error response.
// Build option MAU_MISALIGN_CHECK_EN: when defined, misaligned word/half
// requests skip the bus and complete with resp_err=1; otherwise addresses are
// forwarded unchanged.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE and does not depend on req_valid, and the
// request fields are only sampled on that edge.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] DAD,
   output logic [31:0] DDT_out,
   output logic        DDT_oe,
   input  logic [31:0] DDT_in,
   output logic        MREQ,
   output logic        WRITE,
   output logic [1:0]  SIZE,
   input  logic        ACKD_n,
   output mau_state_t  dbg_state
);

   // Last count value before the wait counter would reach TIMEOUT.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   mau_state_t  state;
   logic        mreq_q;
   logic        write_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [7:0]  wait_cnt;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   logic [1:0]  req_size_n;
   logic        misalign;
   logic [31:0] load_data;
   logic [31:0] store_data;

   assign req_size_n = norm_size(req_size);

`ifdef MAU_MISALIGN_CHECK_EN
   assign misalign = ((req_size_n == SIZE_WORD) && (req_addr[1:0] != 2'b00)) ||
                     ((req_size_n == SIZE_HALF) && req_addr[0]);
`else
   assign misalign = 1'b0;
`endif

   // Steering works off the registered request, so bus data stays stable
   // for the whole BUS phase.
   mau_align u_align (
      .size       (size_q),
      .is_signed  (signed_q),
      .load_raw   (DDT_in),
      .store_raw  (wdata_q),
      .load_data  (load_data),
      .store_data (store_data)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_IDLE;
         mreq_q       <= 1'b0;
         write_q      <= 1'b0;
         size_q       <= SIZE_WORD;
         signed_q     <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         wait_cnt     <= 8'h00;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  addr_q       <= req_addr;
                  write_q      <= req_write;
                  size_q       <= req_size_n;
                  signed_q     <= req_signed;
                  wdata_q      <= req_wdata;
                  wait_cnt     <= 8'h00;
                  resp_rdata_q <= 32'h0;
                  if (misalign) begin
                     state        <= ST_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                  end else begin
                     state      <= ST_BUS;
                     mreq_q     <= 1'b1;
                     resp_err_q <= 1'b0;
                  end
               end
            end
            ST_BUS: begin
               // ACK is checked first so it wins over a same-cycle timeout.
               if (!ACKD_n) begin
                  state        <= ST_RESP;
                  mreq_q       <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= write_q ? 32'h0 : load_data;
               end else if (wait_cnt == WAIT_LAST) begin
                  state        <= ST_RESP;
                  mreq_q       <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= 32'h0;
                  wait_cnt     <= wait_cnt + 8'h01;
               end else begin
                  wait_cnt <= wait_cnt + 8'h01;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state  <= ST_IDLE;
               mreq_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign MREQ       = mreq_q;
   assign WRITE      = write_q;
   assign SIZE       = size_q;
   assign DAD        = addr_q;
   assign DDT_oe     = mreq_q & write_q;
   assign DDT_out    = (mreq_q & write_q) ? store_data : 32'h0;
   assign dbg_state  = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit -- directed and randomized load/store transactions
// against a byte-mask reference model of the memory access unit.
module tb_mem_access_unit;
   import mau_pkg::*;

   localparam int TMO = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] DAD;
   logic [31:0] DDT_out;
   logic        DDT_oe;
   logic [31:0] DDT_in = 32'h0;
   logic        MREQ;
   logic        WRITE;
   logic [1:0]  SIZE;
   logic        ACKD_n = 1'b1;
   mau_state_t  dbg_state;

   mem_access_unit #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .DAD        (DAD),
      .DDT_out    (DDT_out),
      .DDT_oe     (DDT_oe),
      .DDT_in     (DDT_in),
      .MREQ       (MREQ),
      .WRITE      (WRITE),
      .SIZE       (SIZE),
      .ACKD_n     (ACKD_n),
      .dbg_state  (dbg_state)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'b00) ? 4 : (s == 2'b01) ? 2 : 1;
   endfunction

   function automatic logic [31:0] mask_of(input logic [1:0] s);
      logic [31:0] one;
      one = 32'h1;
      if (nbytes(s) == 4) return 32'hffff_ffff;
      return (one << (8 * nbytes(s))) - 32'h1;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] s, input logic sgn,
                                              input logic [31:0] bus);
      logic [31:0] m;
      logic [31:0] v;
      m = mask_of(s);
      v = bus & m;
      if (sgn && nbytes(s) < 4 && v[8 * nbytes(s) - 1]) v = v | ~m;
      return v;
   endfunction

   function automatic bit model_misalign(input logic [1:0] s, input logic [31:0] addr);
`ifdef MAU_MISALIGN_CHECK_EN
      return (addr % nbytes(s)) != 0;
`else
      return (addr != addr);
`endif
   endfunction

   // ---------------- scoreboard ----------------
   logic [32:0] exp_q[$];   // {err, rdata}

   always @(negedge clk) begin
      if (resp_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("resp_unexpected", 33'(resp_valid), 33'h0);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check_eq("resp_err", 33'(resp_err), 33'(e[32]));
            check_eq("resp_rdata", 33'(resp_rdata), 33'(e[31:0]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called just after a falling edge; returns just after a falling edge with
   // the unit back in IDLE. waits = BUS cycles before ACK (>= TMO: never ACK).
   task automatic do_txn(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] bus_data);
      bit          mis;
      bit          err;
      logic [31:0] rdata;
      int          exp_lat;
      int          lat;
      int          k;
      bit          got;
      logic [1:0]  exp_sz;

      mis     = model_misalign(sz, addr);
      err     = mis || (waits >= TMO);
      rdata   = (err || wr) ? 32'h0 : model_load(sz, sgn, bus_data);
      exp_lat = mis ? 2 : 1 + ((waits + 1 < TMO) ? waits + 1 : TMO) + 1;
      exp_sz  = (sz == 2'b11) ? 2'b10 : sz;
      exp_q.push_back({err, rdata});

      check_eq("req_ready_idle", 33'(req_ready), 33'h1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;

      lat = 1;
      k   = 0;
      got = 0;
      for (int c = 0; c < TMO + 6; c++) begin
         @(negedge clk);
         lat++;
         req_valid  = 1'b0;
         req_write  = 1'($urandom);
         req_size   = 2'($urandom);
         req_addr   = $urandom;
         req_wdata  = $urandom;
         if (resp_valid) begin
            got = 1;
            break;
         end
         check_eq("bus_mreq", 33'(MREQ), 33'h1);
         check_eq("bus_dad", 33'(DAD), 33'(addr));
         check_eq("bus_write", 33'(WRITE), 33'(wr));
         check_eq("bus_size", 33'(SIZE), 33'(exp_sz));
         check_eq("bus_oe", 33'(DDT_oe), 33'(wr));
         check_eq("bus_wdata", 33'(DDT_out), 33'(wr ? (wdata & mask_of(sz)) : 32'h0));
         check_eq("req_ready_busy", 33'(req_ready), 33'h0);
         if (k == waits) begin
            ACKD_n = 1'b0;
            DDT_in = bus_data;
         end else begin
            ACKD_n = 1'b1;
            DDT_in = $urandom;
         end
         k++;
      end
      check_eq("resp_seen", 33'(got), 33'h1);
      check_eq("latency", 33'(lat), 33'(exp_lat));
      check_eq("resp_mreq_low", 33'(MREQ), 33'h0);
      check_eq("resp_oe_low", 33'(DDT_oe), 33'h0);
      ACKD_n = 1'b1;
      @(negedge clk);
      check_eq("resp_one_cycle", 33'(resp_valid), 33'h0);
      check_eq("back_idle", 33'(req_ready), 33'h1);
   endtask

   task automatic reset_mid_bus();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_size  = 2'b00;
      req_addr  = 32'h0800_0010;
      @(negedge clk);
      req_valid = 1'b0;
      check_eq("rbus_mreq", 33'(MREQ), 33'h1);
      rst    = 1'b0;
      ACKD_n = 1'b0;
      DDT_in = 32'hdead_beef;
      @(negedge clk);
      check_eq("rbus_mreq_low", 33'(MREQ), 33'h0);
      check_eq("rbus_no_resp", 33'(resp_valid), 33'h0);
      check_eq("rbus_ready", 33'(req_ready), 33'h1);
      rst    = 1'b1;
      @(negedge clk);
      check_eq("rbus_no_resp2", 33'(resp_valid), 33'h0);
      check_eq("rbus_mreq_low2", 33'(MREQ), 33'h0);
      ACKD_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic spurious_ack();
      ACKD_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("sp_mreq", 33'(MREQ), 33'h0);
         check_eq("sp_resp", 33'(resp_valid), 33'h0);
         check_eq("sp_ready", 33'(req_ready), 33'h1);
      end
      ACKD_n = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 33'(req_ready), 33'h1);
      check_eq("rst_mreq", 33'(MREQ), 33'h0);
      check_eq("rst_write", 33'(WRITE), 33'h0);
      check_eq("rst_size", 33'(SIZE), 33'h0);
      check_eq("rst_dad", 33'(DAD), 33'h0);
      check_eq("rst_oe", 33'(DDT_oe), 33'h0);
      check_eq("rst_ddt_out", 33'(DDT_out), 33'h0);
      check_eq("rst_resp_valid", 33'(resp_valid), 33'h0);
      check_eq("rst_resp_err", 33'(resp_err), 33'h0);
      check_eq("rst_resp_rdata", 33'(resp_rdata), 33'h0);
      rst = 1'b1;
      @(negedge clk);

      // Directed cases
      do_txn(1'b0, 2'b00, 1'b0, 32'h0800_0000, 32'h0, 0, 32'h1122_3344);
      do_txn(1'b0, 2'b10, 1'b1, 32'h0800_0001, 32'h0, 0, 32'h0000_0080);
      do_txn(1'b0, 2'b10, 1'b0, 32'h0800_0001, 32'h0, 0, 32'h0000_0080);
      do_txn(1'b0, 2'b01, 1'b1, 32'h0800_0002, 32'h0, 1, 32'h1234_8001);
      do_txn(1'b0, 2'b11, 1'b1, 32'h0800_0003, 32'h0, 2, 32'h5555_55ff);
      do_txn(1'b1, 2'b01, 1'b0, 32'h0800_0004, 32'hABCD_1234, 3, 32'h0);
      do_txn(1'b0, 2'b00, 1'b0, 32'h0800_0008, 32'h0, 99, 32'h0);
      do_txn(1'b1, 2'b10, 1'b0, STDOUT_ADDR, 32'h0000_0041, 0, 32'h0);
      do_txn(1'b1, 2'b00, 1'b0, EXIT_ADDR, 32'h0000_0000, 1, 32'h0);
      do_txn(1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0, 0, 32'hcafe_f00d);
      reset_mid_bus();
      spurious_ack();

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         logic [31:0] a;
         int sel;
         sel = $urandom_range(0, 9);
         a   = (sel == 0) ? STDOUT_ADDR : (sel == 1) ? EXIT_ADDR : $urandom;
         do_txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                $urandom_range(0, TMO + 1), $urandom);
      end

      repeat (2) @(negedge clk);
      check_eq("exp_q_drained", 33'(exp_q.size()), 33'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
